line_crash_ctrl: RTL
====================

# line_crash_ctrl

Game-state and collision controller for the Wild Cube line field. Sits directly upstream of the line generators (vline_N stages): consumes their per-pixel line masks and the player cube pixel mask, detects overlap during active scan, and produces the `stop` and `flash` controls every line stage uses to freeze and blink. It also keeps a survival score and latches which line caused the crash.

## Interface
- `NUM_LINES`, 8: number of line stages feeding `line_px`
- `HIT_THRESH`, 4: overlapping pixels within one frame that constitute a crash (1..255)
- `ARM_FRAMES`, 60: grace frames after start during which collisions are ignored (1..255)
- `FLASH_DIV`, 15: frames per flash half-period in CRASH (1..255)

- `clk` in 1: pixel clock, sole clock
- `reset` in 1: synchronous, active-low reset
- `frame` in 1: one-`clk` pulse per video frame (end of frame), synchronous to `clk`
- `start` in 1: one-`clk` start/restart pulse (debounced button)
- `line_px` in NUM_LINES: per-line pixel-on (`sha2` of each stage), bit i = stage i
- `cube_px` in 1: player cube pixel-on at current scan position
- `stop` out 1: 1 = lines move and draw steady; 0 = lines frozen and gated by `flash`
- `flash` out 1: blink enable to line stages
- `crash` out 1: high while in CRASH
- `crash_line` out 3: lowest index of `line_px` set on the crashing overlap cycle
- `score` out 16: frames survived in PLAY, saturating

## Operation
- States: IDLE, ARM, PLAY, CRASH (encoding in package).
- IDLE: stop=0, flash=1 (lines drawn frozen, steady). `start` -> ARM.
- ARM: stop=1. Load arm counter with ARM_FRAMES on entry; decrement on each `frame`; on the `frame` that takes it to 0 -> PLAY. Overlaps ignored; hit counter held at 0. `start` ignored.
- PLAY: stop=1, flash=1. `overlap = cube_px & |line_px`. Hit counter (8-bit, saturating) increments on each overlap cycle, clears on `frame`; if `frame` and overlap coincide, counter loads 1. When an overlap cycle brings the counter to HIT_THRESH -> CRASH; `crash_line` captured from that same cycle's `line_px` (lowest set bit). `score` increments on each `frame`, saturates at 16'hFFFF. `start` ignored.
- CRASH: stop=0, crash=1. On entry flash=0 and flash divider=0. Divider counts `frame` pulses; at FLASH_DIV-1 toggle flash, divider -> 0. `score` and `crash_line` frozen. `start` -> ARM, clears `score`, `crash_line`, hit counter; flash -> 1.
- `start` and crash-threshold on the same cycle in PLAY: crash wins.
- `line_px` bits at index >= NUM_LINES do not exist; `crash_line` is 0 when NUM_LINES=1.

## Timing
- All outputs registered; reset values: state IDLE, stop=0, flash=1, crash=0, crash_line=0, score=0, internal counters 0.
- Reset applies on the first `clk` edge with `reset`=0, regardless of state or pending pulses.
- `start` -> state/outputs change on the next `clk` edge (1-cycle latency).
- Threshold-reaching overlap at cycle t -> crash=1, stop=0, flash=0 at t+1.
- ARM->PLAY: stop stays 1 across the boundary; first PLAY-counted frame is the following `frame`.
- Flash first toggles to 1 on the FLASH_DIV-th `frame` after CRASH entry.

## Structure
- Package `wildcube_pkg`: state enum, `SCORE_W`=16, `LINE_IDX_W`=3, `HIT_W`=8.
- One sub-module: `frame_tick_counter` (loadable 8-bit down-counter advancing on `frame`, terminal-count flag), instantiated twice: ARM timer and flash divider.
- Priority encoder for `crash_line` inline.

## Test plan
- Reset mid-PLAY with score=37 -> next edge: IDLE, stop=0, flash=1, score=0, crash=0.
- start in IDLE, ARM_FRAMES=3, overlap every cycle during ARM -> no crash; PLAY entered on 3rd `frame`; stop=1 throughout.
- PLAY, HIT_THRESH=4, 4 overlap cycles with `line_px`=8'b0010_0100 -> crash=1 one cycle after 4th, crash_line=2, flash=0.
- PLAY, 3 overlaps, `frame`, 3 overlaps -> no crash (counter cleared); overlap coincident with `frame` counts as 1.
- CRASH, FLASH_DIV=2 -> flash toggles every 2nd `frame` (0,0,1,1,0...); score frozen; start -> ARM, score=0, flash=1.
- 70000 frames in PLAY with no overlap -> score saturates at 16'hFFFF.

Source files
------------

// File: rtl/wildcube_pkg.sv
// Shared types and widths for the Wild Cube line-field game controller.
package wildcube_pkg;

    localparam int SCORE_W    = 16;
    localparam int LINE_IDX_W = 3;
    localparam int HIT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_PLAY  = 2'd2,
        ST_CRASH = 2'd3
    } state_e;

endpackage

// File: rtl/line_crash_ctrl_if.sv
// Bundle between the video/line-stage side (master) and the crash controller (slave).
interface line_crash_ctrl_if #(
    parameter int NUM_LINES = 8
);
    logic                                 frame;
    logic                                 start;
    logic [NUM_LINES-1:0]                 line_px;
    logic                                 cube_px;
    logic                                 stop;
    logic                                 flash;
    logic                                 crash;
    logic [wildcube_pkg::LINE_IDX_W-1:0]  crash_line;
    logic [wildcube_pkg::SCORE_W-1:0]     score;

    modport master (
        output frame, start, line_px, cube_px,
        input  stop, flash, crash, crash_line, score
    );

    modport slave (
        input  frame, start, line_px, cube_px,
        output stop, flash, crash, crash_line, score
    );
endinterface

// File: rtl/frame_tick_counter.sv
// Loadable down-counter stepped by frame pulses; tc_o marks the tick that reaches zero.
module frame_tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = tick_i && (cnt_q == W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/line_crash_ctrl.sv
// Game-state / collision controller: drives stop and flash for the line stages,
// keeps the survival score and latches the line that caused the crash.
module line_crash_ctrl
    import wildcube_pkg::*;
#(
    parameter int NUM_LINES  = 8,
    parameter int HIT_THRESH = 4,
    parameter int ARM_FRAMES = 60,
    parameter int FLASH_DIV  = 15
) (
    input  logic              clk,
    input  logic              reset,
    line_crash_ctrl_if.slave  bus
);
    state_e                  state_q, state_d;
    logic [HIT_W-1:0]        hit_q, hit_d;
    logic [SCORE_W-1:0]      score_q, score_d;
    logic [LINE_IDX_W-1:0]   line_q, line_d;
    logic                    stop_q, stop_d;
    logic                    flash_q, flash_d;
    logic                    crash_q, crash_d;

    logic                    overlap;
    logic [LINE_IDX_W-1:0]   line_idx;
    logic                    arm_load, arm_tick, arm_tc;
    logic                    flash_load, flash_tick, flash_tc;

    assign overlap    = bus.cube_px & (|bus.line_px);
    assign arm_tick   = bus.frame && (state_q == ST_ARM);
    assign flash_tick = bus.frame && (state_q == ST_CRASH);

    frame_tick_counter #(.W(HIT_W)) u_arm_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (arm_load),
        .load_val_i (HIT_W'(ARM_FRAMES)),
        .tick_i     (arm_tick),
        .tc_o       (arm_tc)
    );

    frame_tick_counter #(.W(HIT_W)) u_flash_div (
        .clk        (clk),
        .reset      (reset),
        .load_i     (flash_load),
        .load_val_i (HIT_W'(FLASH_DIV)),
        .tick_i     (flash_tick),
        .tc_o       (flash_tc)
    );

    // Lowest set line wins: scan downward so the last match is the smallest index.
    always_comb begin
        line_idx = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (bus.line_px[i]) line_idx = LINE_IDX_W'(i);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        hit_d      = hit_q;
        score_d    = score_q;
        line_d     = line_q;
        stop_d     = stop_q;
        flash_d    = flash_q;
        crash_d    = crash_q;
        arm_load   = 1'b0;
        flash_load = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_ARM;
                    arm_load = 1'b1;
                    stop_d   = 1'b1;
                    flash_d  = 1'b1;
                end
            end
            ST_ARM: begin
                hit_d = '0;
                if (arm_tc) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.frame) begin
                    hit_d = overlap ? HIT_W'(1) : '0;
                    if (score_q != '1) score_d = score_q + SCORE_W'(1);
                end else if (overlap && (hit_q != '1)) begin
                    hit_d = hit_q + HIT_W'(1);
                end
                if (overlap && (hit_d == HIT_W'(HIT_THRESH))) begin
                    state_d    = ST_CRASH;
                    line_d     = line_idx;
                    stop_d     = 1'b0;
                    flash_d    = 1'b0;
                    crash_d    = 1'b1;
                    flash_load = 1'b1;
                end
            end
            ST_CRASH: begin
                if (bus.start) begin
                    state_d  = ST_ARM;
                    arm_load = 1'b1;
                    hit_d    = '0;
                    score_d  = '0;
                    line_d   = '0;
                    stop_d   = 1'b1;
                    flash_d  = 1'b1;
                    crash_d  = 1'b0;
                end else if (flash_tc) begin
                    flash_d    = ~flash_q;
                    flash_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hit_q   <= '0;
            score_q <= '0;
            line_q  <= '0;
            stop_q  <= 1'b0;
            flash_q <= 1'b1;
            crash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            score_q <= score_d;
            line_q  <= line_d;
            stop_q  <= stop_d;
            flash_q <= flash_d;
            crash_q <= crash_d;
        end
    end

    assign bus.stop       = stop_q;
    assign bus.flash      = flash_q;
    assign bus.crash      = crash_q;
    assign bus.crash_line = line_q;
    assign bus.score      = score_q;
endmodule
